// File: rtl/icache.sv
// Direct-mapped instruction cache. One fetch at a time: latch PC, check
// line A (and line B when a full-width instruction straddles lines),
// refill missing lines word by word, then pulse have_result.
module icache #(
    parameter int OFFSET_BITS = 4,  // must be >= 3 (at least two words per line)
    parameter int INDEX_BITS  = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        to_icache,
    input  logic [31:0] pc_to_icache,
    output logic        have_result,
    output logic [31:0] inst_from_icache,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_valid,
    input  logic [31:0] mem_data
);
    localparam int WORDS  = 1 << (OFFSET_BITS - 2);
    localparam int LINES  = 1 << INDEX_BITS;
    localparam int TAG_W  = 32 - OFFSET_BITS - INDEX_BITS;
    localparam int CNT_W  = OFFSET_BITS - 2;
    localparam int LINE_W = 32 - OFFSET_BITS;  // line number width

    typedef enum logic [1:0] {IDLE, CHECK, FILL, RESP} state_t;

    // storage: data and tags are never reset, only the valid bits are
    logic [31:0]      data_q  [LINES][WORDS];
    logic [TAG_W-1:0] tag_q   [LINES];
    logic [LINES-1:0] valid_q, valid_d;

    state_t           state_q, state_d;
    logic [31:1]      pc_q, pc_d;            // halfword address of the fetch
    logic [LINE_W-1:0] fill_line_q, fill_line_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             have_result_q, have_result_d;
    logic [31:0]      inst_q, inst_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;

    // PC bit 0 is always zero for 2-byte aligned fetches
    logic unused_pc0;
    assign unused_pc0 = pc_to_icache[0];

    // line A holds pc, line B holds pc+2 (same line unless pc is the last halfword)
    logic [31:1]       pc_b;
    logic [LINE_W-1:0] line_a, line_b;
    logic [INDEX_BITS-1:0] idx_a, idx_b;
    logic [TAG_W-1:0]  tag_a, tag_b;
    logic              hit_a, hit_b, full_w, straddle, need_b;
    logic [31:0]       word_a, word_b;
    logic [15:0]       hw_a, hw_b;
    logic              fill_we, fill_last;

    assign pc_b     = pc_q + 31'd1;
    assign line_a   = pc_q[31:OFFSET_BITS];
    assign line_b   = pc_b[31:OFFSET_BITS];
    assign idx_a    = line_a[INDEX_BITS-1:0];
    assign idx_b    = line_b[INDEX_BITS-1:0];
    assign tag_a    = line_a[LINE_W-1 -: TAG_W];
    assign tag_b    = line_b[LINE_W-1 -: TAG_W];
    assign hit_a    = valid_q[idx_a] && (tag_q[idx_a] == tag_a);
    assign hit_b    = valid_q[idx_b] && (tag_q[idx_b] == tag_b);
    assign word_a   = data_q[idx_a][pc_q[OFFSET_BITS-1:2]];
    assign word_b   = data_q[idx_b][pc_b[OFFSET_BITS-1:2]];
    assign hw_a     = pc_q[1] ? word_a[31:16] : word_a[15:0];
    assign hw_b     = pc_b[1] ? word_b[31:16] : word_b[15:0];
    assign full_w   = (hw_a[1:0] == 2'b11);
    assign straddle = &pc_q[OFFSET_BITS-1:1];
    assign need_b   = full_w && straddle;

    assign fill_we   = rdy_in && (state_q == FILL) && mem_valid;
    assign fill_last = (cnt_q == {CNT_W{1'b1}});

    // next-state, refill sequencing and result generation; frozen while !rdy_in
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fill_line_d   = fill_line_q;
        cnt_d         = cnt_q;
        have_result_d = have_result_q;
        inst_d        = inst_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        valid_d       = valid_q;
        if (rdy_in) begin
            have_result_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (to_icache) begin
                        pc_d    = pc_to_icache[31:1];
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!hit_a || (need_b && !hit_b)) begin
                        fill_line_d = hit_a ? line_b : line_a;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {fill_line_d, {OFFSET_BITS{1'b0}}};
                        state_d     = FILL;
                    end else begin
                        inst_d        = full_w ? {hw_b, hw_a} : {16'h0000, hw_a};
                        have_result_d = 1'b1;
                        state_d       = IDLE;
                    end
                end
                FILL: begin
                    if (mem_valid) begin
                        cnt_d = cnt_q + 1'b1;
                        if (fill_last) begin
                            valid_d[fill_line_q[INDEX_BITS-1:0]] = 1'b1;
                            mem_req_d = 1'b0;
                            state_d   = CHECK;
                        end else begin
                            mem_addr_d = {fill_line_q, cnt_d, 2'b00};
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // control and output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            fill_line_q   <= '0;
            cnt_q         <= '0;
            have_result_q <= 1'b0;
            inst_q        <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            valid_q       <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fill_line_q   <= fill_line_d;
            cnt_q         <= cnt_d;
            have_result_q <= have_result_d;
            inst_q        <= inst_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            valid_q       <= valid_d;
        end
    end

    // refill writes into the data/tag arrays; a reset cycle drops the beat
    always_ff @(posedge clk_in) begin
        if (fill_we && !rst_in) begin
            data_q[fill_line_q[INDEX_BITS-1:0]][cnt_q] <= mem_data;
            if (fill_last)
                tag_q[fill_line_q[INDEX_BITS-1:0]] <= fill_line_q[LINE_W-1 -: TAG_W];
        end
    end

    assign have_result      = have_result_q;
    assign inst_from_icache = inst_q;
    assign mem_req          = mem_req_q;
    assign mem_addr         = mem_addr_q;
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between instruction fetch and the memory arbiter. It accepts a one-cycle fetch request carrying a 2-byte-aligned PC and returns a 32-bit instruction word with a one-cycle `have_result` pulse. Misses are refilled one 32-bit word at a time over the memory port. A request whose 4 bytes straddle two cache lines is served from both lines, refilling each as needed.

## Interface
- `OFFSET_BITS`, 4: log2 line size in bytes (16 B line, 4 words)
- `INDEX_BITS`, 6: log2 number of lines (64); tag = `pc[31:OFFSET_BITS+INDEX_BITS]`
- `clk_in` in 1: clock, single domain
- `rst_in` in 1: reset, synchronous, active-high
- `rdy_in` in 1: global pause when low; all state frozen
- `to_icache` in 1: fetch request pulse
- `pc_to_icache` in 32: fetch address, bit 0 always 0
- `have_result` out 1: one-cycle result pulse
- `inst_from_icache` out 32: instruction; valid only while `have_result`=1
- `mem_req` out 1: word read request to arbiter
- `mem_addr` out 32: word-aligned read address
- `mem_valid` in 1: one-cycle read-data strobe
- `mem_data` in 32: read data, little-endian

## Operation
- Storage per line: valid bit, tag, 2^OFFSET_BITS bytes of data. Line A = line containing `pc`. Line B = line containing `pc+2`; it is needed only when `pc[OFFSET_BITS-1:0]` == line_bytes−2.
- Compressed rule: if halfword(pc)[1:0] != 2'b11, line B is never needed, and `inst[31:16]` = 0. Otherwise `inst` = {halfword(pc+2), halfword(pc)}.
- States: IDLE, CHECK, FILL, RESP.
- IDLE: if `to_icache`=1, latch pc and go to CHECK. Requests arriving in any other state are ignored; fetch never issues them.
- CHECK:
  - A invalid or tag mismatch: FILL(A).
  - Else B needed and B misses: FILL(B).
  - Else: drive `inst`, pulse `have_result`, go to IDLE.
- FILL: 2-bit word counter (generally OFFSET_BITS−2 bits) from 0.
  - `mem_addr` = line_base + 4·cnt, `mem_req`=1.
  - On `mem_valid`: write `mem_data` into word cnt, cnt++.
  - After the last word: set valid and tag, drop `mem_req`, return to CHECK. CHECK re-evaluates, so a straddling double miss does FILL(A), CHECK, FILL(B), CHECK.
  - Refill overwrites the victim line unconditionally. There is no dirty state.
- A request that fetch has abandoned (misprediction) is still completed and pulsed. Fetch discards the result. No cancel input exists.
- Fill order is A before B. If A and B map to the same index (INDEX_BITS=0 only), that configuration is unsupported.

## Timing
- Reset values: `have_result`=0, `inst_from_icache`=0, `mem_req`=0, `mem_addr`=0, all valid bits 0, state IDLE, counter 0. Data/tag arrays are not reset.
- Reset mid-refill: partial line discarded (valid stays 0). Any `mem_valid` arriving after reset is ignored.
- Hit latency: request sampled at edge E0, CHECK during E0→E1, `have_result` high for exactly cycle E1→E2.
- `have_result` is registered and never high two consecutive cycles. A new request may arrive in the cycle `have_result` is high, since state is IDLE then. It is accepted at that edge.
- Memory handshake:
  - `mem_req`/`mem_addr` are registered.
  - `mem_req` stays high until `mem_valid`.
  - On a `mem_valid` edge, the next word's address is presented the following cycle with `mem_req` still 1, so back-to-back beats are allowed.
  - `mem_req` is low the cycle after the last beat.
- Miss latency: 1 (CHECK) + per-word memory latency × words + 1 (CHECK) + result cycle.
- `rdy_in`=0: no state, counter, array, or output register changes. The arbiter shares `rdy_in` and never asserts `mem_valid` while it is low.

## Test plan
- Cold miss: request pc=0x0, memory returns 0x00000013, 0x11, 0x22, 0x33 with 2-cycle latency → `mem_addr` sequence 0x0, 0x4, 0x8, 0xC. One `have_result` with `inst`=0x00000013.
- Hit: after the cold miss, request pc=0x4 → `have_result` exactly 1 cycle after the sampling edge, `inst`=0x11, `mem_req` never rises.
- Straddle:
  - pc=0xE, line 0 holds halfword 0x0297 at 0xE, memory holds 0x0000 at 0x10 → line 0x10 refilled (`mem_addr` 0x10..0x1C), then `inst`=0x00000297.
  - With 0x4501 at 0xE instead (compressed) → no refill, `inst`=0x00004501.
- Conflict: fill pc=0x0, then request pc=0x400 (same index, different tag) → refill 0x400..0x40C. A following request to pc=0x0 misses and refills again.
- Reset mid-refill: assert `rst_in` after the 2nd beat of a fill → `mem_req`=0 next cycle. A subsequent request to the same line performs a full 4-beat refill.
- Pause: hold `rdy_in`=0 for 5 cycles during FILL and in the `have_result` cycle → counter, `mem_addr`, and `have_result` hold unchanged. Exactly one result pulse after `rdy_in` returns to 1.
